// File: rtl/sprite_index_fetch.sv
// Sprite bounding-box test, ROM address generation and frame-rate animation counter.
// Optional horizontal mirroring is compiled in with `define SPRITE_HFLIP_EN.
module sprite_index_fetch #(
    parameter int         SPR_W      = 64,
    parameter int         SPR_H      = 64,
    parameter int         NUM_FRAMES = 4,
    parameter int         FRAME_DIV  = 6,
    parameter int         ROM_LAT    = 1,
    parameter int         ADDR_W     = 16,
    parameter logic [3:0] TRANSP_IDX = 4'd0,
    localparam int        FN_W       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              anim_en,
    input  logic              pix_valid,
`ifdef SPRITE_HFLIP_EN
    input  logic              facing_left,
`endif
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        SpriteX,
    input  logic [9:0]        SpriteY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        index,
    output logic              in_sprite,
    output logic              transparent,
    output logic [FN_W-1:0]   frame_num
);

    localparam int          L        = 1 + ROM_LAT;
    localparam int          COL_W    = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int          DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int          FRAME_SZ = SPR_W * SPR_H;
    localparam logic [10:0] SPR_W_L  = 11'(SPR_W);
    localparam logic [10:0] SPR_H_L  = 11'(SPR_H);

    typedef enum logic {
        IDLE,
        RUN
    } anim_state_t;

    anim_state_t       state, state_n;
    logic [DIV_W-1:0]  div_cnt, div_n;
    logic [FN_W-1:0]   frame_n;

    logic [10:0]       rel_x, rel_y;
    logic              hit;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] addr_calc;
    logic [L-1:0]      hit_pipe;

    // ---------------- animation FSM ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            frame_num <= '0;
        end else begin
            state     <= state_n;
            div_cnt   <= div_n;
            frame_num <= frame_n;
        end
    end

    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        frame_n = frame_num;
        case (state)
            IDLE:    if (anim_en)  state_n = RUN;
            RUN:     if (!anim_en) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Counting keys off the next state, so a pulse coinciding with IDLE->RUN
        // counts and a pulse after anim_en drops clears the counters.
        if (frame_start) begin
            if (state_n == RUN) begin
                if (div_cnt == DIV_W'(FRAME_DIV - 1)) begin
                    div_n   = '0;
                    frame_n = (frame_num == FN_W'(NUM_FRAMES - 1)) ? '0 : frame_num + 1'b1;
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end else begin
                div_n   = '0;
                frame_n = '0;
            end
        end
    end

    // ---------------- hit test and address ----------------
    always_comb begin
        rel_x = {1'b0, DrawX} - {1'b0, SpriteX};
        rel_y = {1'b0, DrawY} - {1'b0, SpriteY};
        hit   = pix_valid
              && !rel_x[10] && (rel_x < SPR_W_L)
              && !rel_y[10] && (rel_y < SPR_H_L);
    end

`ifdef SPRITE_HFLIP_EN
    logic face_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            face_q <= 1'b0;
        end else if (frame_start) begin
            face_q <= facing_left;
        end
    end

    // SPR_W is a power of two, so SPR_W-1-x is the bitwise inverse of x.
    assign col = face_q ? ~rel_x[COL_W-1:0] : rel_x[COL_W-1:0];
`else
    assign col = rel_x[COL_W-1:0];
`endif

    assign addr_calc = ADDR_W'(frame_num) * ADDR_W'(FRAME_SZ)
                     + ADDR_W'(rel_y) * ADDR_W'(SPR_W)
                     + ADDR_W'(col);

    // ---------------- pipeline ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr <= '0;
            hit_pipe <= '0;
        end else begin
            rom_addr <= hit ? addr_calc : '0;
            hit_pipe <= {hit_pipe[L-2:0], hit};
        end
    end

    always_comb begin
        in_sprite   = hit_pipe[L-1];
        index       = in_sprite ? rom_data : TRANSP_IDX;
        transparent = !in_sprite || (index == TRANSP_IDX);
    end

endmodule

// File: tb/tb_sprite_index_fetch.sv
// Randomized check of sprite_index_fetch against a pixel-level reference model.
module tb_sprite_index_fetch;

    localparam int SPR_W      = 64;
    localparam int SPR_H      = 64;
    localparam int NUM_FRAMES = 4;
    localparam int FRAME_DIV  = 6;
    localparam int ROM_LAT    = 1;
    localparam int ADDR_W     = 16;
    localparam int L          = 1 + ROM_LAT;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              frame_start = 1'b0;
    logic              anim_en = 1'b0;
    logic              pix_valid = 1'b0;
    logic              facing_left = 1'b0;
    logic [9:0]        DrawX = '0, DrawY = '0, SpriteX = '0, SpriteY = '0;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data;
    logic [3:0]        index;
    logic              in_sprite;
    logic              transparent;
    logic [1:0]        frame_num;

    sprite_index_fetch #(
        .SPR_W     (SPR_W),
        .SPR_H     (SPR_H),
        .NUM_FRAMES(NUM_FRAMES),
        .FRAME_DIV (FRAME_DIV),
        .ROM_LAT   (ROM_LAT),
        .ADDR_W    (ADDR_W),
        .TRANSP_IDX(4'd0)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_start(frame_start),
        .anim_en    (anim_en),
        .pix_valid  (pix_valid),
`ifdef SPRITE_HFLIP_EN
        .facing_left(facing_left),
`endif
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .SpriteX    (SpriteX),
        .SpriteY    (SpriteY),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .index      (index),
        .in_sprite  (in_sprite),
        .transparent(transparent),
        .frame_num  (frame_num)
    );

    always #5 Clk = ~Clk;

    // sprite ROM with ROM_LAT-cycle read latency
    logic [3:0] rom_mem [0:65535];
    logic [3:0] rom_pipe [ROM_LAT];
    always @(posedge Clk) begin
        rom_pipe[0] <= rom_mem[rom_addr];
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    typedef struct {
        bit hit;
        int addr;
    } pix_t;

    pix_t q[$];
    int   m_pulses;
    bit   m_face;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        pix_t miss;
        miss.hit  = 1'b0;
        miss.addr = 0;
        m_pulses  = 0;
        m_face    = 1'b0;
        q.delete();
        for (int i = 0; i < L; i++) q.push_back(miss);
    endtask

    task automatic do_reset();
        Reset       = 1'b1;
        frame_start = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_rom_addr", rom_addr, 0);
        check("rst_index", index, 0);
        check("rst_in_sprite", in_sprite, 0);
        check("rst_transparent", transparent, 1);
        check("rst_frame_num", frame_num, 0);
        Reset = 1'b0;
        model_clear();
    endtask

    // one pixel clock: predict from current inputs, clock, compare every output
    task automatic step();
        pix_t e, o;
        int   rx, ry, col, exp_idx;
        rx     = int'(DrawX) - int'(SpriteX);
        ry     = int'(DrawY) - int'(SpriteY);
        e.hit  = pix_valid && rx >= 0 && rx < SPR_W && ry >= 0 && ry < SPR_H;
        col    = m_face ? (SPR_W - 1 - rx) : rx;
        e.addr = e.hit ? ((m_pulses / FRAME_DIV) % NUM_FRAMES) * SPR_W * SPR_H + ry * SPR_W + col : 0;
        q.push_back(e);
        @(posedge Clk);
        #1;
        if (frame_start) begin
            if (anim_en) m_pulses++;
            else         m_pulses = 0;
`ifdef SPRITE_HFLIP_EN
            m_face = facing_left;
`endif
        end
        check("rom_addr", rom_addr, e.addr);
        if (q.size() > L) void'(q.pop_front());
        o       = q[0];
        exp_idx = o.hit ? int'(rom_mem[o.addr]) : 0;
        check("in_sprite", in_sprite, o.hit);
        check("index", index, exp_idx);
        check("transparent", transparent, (!o.hit || exp_idx == 0) ? 1 : 0);
        check("frame_num", frame_num, (m_pulses / FRAME_DIV) % NUM_FRAMES);
    endtask

    task automatic pix(input int x, input int y, input bit pv);
        DrawX     = 10'(x);
        DrawY     = 10'(y);
        pix_valid = pv;
        step();
    endtask

    task automatic pulses(input int n);
        pix_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom_mem[i] = 4'($urandom);
        rom_mem[0] = 4'h5;
        rom_mem[1] = 4'h0;
        for (int i = 0; i < ROM_LAT; i++) rom_pipe[i] = '0;

        do_reset();

        // basic hit / address / edge of box
        SpriteX = 10'd100;
        SpriteY = 10'd50;
        pix(100, 50, 1);
        check("t2_addr0", rom_addr, 0);
        pix(163, 51, 1);
        check("t2_addr127", rom_addr, 127);
        check("t2_index5", index, 5);
        pix(164, 51, 1);
        pix(100, 49, 1);
        check("t2_right_miss", in_sprite, 0);
        pix(99, 50, 1);

        // animation counter
        anim_en = 1'b1;
        pix(0, 0, 0);
        pulses(6);
        check("t3_frame1", frame_num, 1);
        pix(100, 50, 1);
        check("t3_addr4096", rom_addr, 4096);
        pulses(12);
        check("t3_frame3", frame_num, 3);
        pulses(6);
        check("t3_wrap", frame_num, 0);
        pulses(12);
        anim_en = 1'b0;
        pix(0, 0, 0);
        pulses(1);
        check("t3_drop", frame_num, 0);

        // transparent colour and pix_valid gating
        pix(101, 50, 1);
        pix(101, 50, 0);
        check("t4_tr_in", in_sprite, 1);
        check("t4_tr_flag", transparent, 1);
        pix(0, 0, 0);
        check("t4_pv_gate", in_sprite, 0);

        // right-edge and wrap boundaries
        SpriteX = 10'd600;
        SpriteY = 10'd0;
        pix(639, 5, 1);
        pix(0, 0, 0);
        check("t5_hit639", in_sprite, 1);
        SpriteX = 10'd620;
        pix(10, 5, 1);
        pix(0, 0, 0);
        check("t5_nowrap", in_sprite, 0);
        pix(620, 5, 1);
        pix(621, 6, 1);
        do_reset();
        pix(620, 5, 1);
        check("t5_flush", transparent, 1);
        pix(621, 5, 1);

`ifdef SPRITE_HFLIP_EN
        facing_left = 1'b1;
        pulses(1);
        pix(620, 0, 1);
        check("t6_flip63", rom_addr, 63);
        facing_left = 1'b0;
        pix(620, 0, 1);
        check("t6_hold", rom_addr, 63);
        pulses(1);
        pix(620, 0, 1);
        check("t6_unflip", rom_addr, 0);
`endif

        // randomized traffic
        anim_en = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 24 == 0) begin
                SpriteX = 10'($urandom_range(0, 639));
                SpriteY = 10'($urandom_range(0, 479));
            end
            if ($urandom_range(0, 7) == 0) begin
                DrawX = 10'($urandom);
                DrawY = 10'($urandom);
            end else begin
                DrawX = 10'(int'(SpriteX) + int'($urandom_range(0, 143)) - 40);
                DrawY = 10'(int'(SpriteY) + int'($urandom_range(0, 143)) - 40);
            end
            pix_valid   = ($urandom_range(0, 9) != 0);
            frame_start = ($urandom_range(0, 19) == 0);
            if (!frame_start && $urandom_range(0, 299) == 0) anim_en = ~anim_en;
            if ($urandom_range(0, 49) == 0) facing_left = ~facing_left;
            if ($urandom_range(0, 799) == 0) do_reset();
            else step();
        end
        frame_start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
